inccomp_n: RTL and testbench
============================

Name: inccomp_n

Overview:
- Parametrised successor of the two-channel increment/compare block.
- Holds NCH independent unsigned event counters of WIDTH bits, each advanced by its own increment strobe and cleared by its own clear strobe.
- Registers the maximum of the counters' next values and the index of the winning channel.
- Adds selectable wrap or saturate mode, per-channel sticky overflow flags and an update-valid pulse.
- Sits in the low-power test designs as a switching-activity workload for SAIF annotation.

Parameters:
- WIDTH, 8, counter and C width in bits (>=2).
- NCH, 4, number of channels (>=2).
- SAT, 0, overflow mode: 0 = wrap to 0, 1 = saturate at 2^WIDTH-1.
- IW, $clog2(NCH), width of max_idx (derived, not overridden).

Ports:
- ck  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-low (sampled on rising ck; 0 = reset).
- INC  in  NCH  per-channel increment strobe, bit i for channel i.
- CLR  in  NCH  per-channel synchronous clear strobe.
- C  out  WIDTH  registered maximum of the channel counters.
- max_idx  out  IW  registered index of the channel holding C.
- c_valid  out  1  one-cycle pulse; C/max_idx were updated at this edge.
- ovf  out  NCH  sticky per-channel overflow flags.

Behaviour:
- Reset (rst=0 at a rising edge): all counters, C, max_idx, c_valid and ovf go to 0. Reset overrides INC/CLR in that cycle. Reset asserted mid-count discards all state; the first post-reset cycle behaves as from power-up.
- Per channel i, next count nxt[i]:
  - CLR[i]=1 -> 0. Clear wins over INC[i].
  - Else INC[i]=1 -> cnt[i]+1, modulo 2^WIDTH when SAT=0; held at 2^WIDTH-1 when SAT=1 and cnt[i] is already all-ones.
  - Else hold.
  - cnt[i] <= nxt[i] every cycle.
- ovf[i]:
  - Set when INC[i]=1, CLR[i]=0 and cnt[i]=2^WIDTH-1, in both modes.
  - Cleared only by CLR[i] or reset.
  - CLR[i] together with an overflowing INC[i] leaves ovf[i]=0.
  - Output directly from its register.
- Update condition: upd = OR-reduce(INC | CLR).
  - upd=1: C <= max over i of nxt[i] (unsigned); max_idx <= lowest i with nxt[i] equal to that max.
  - upd=0: C and max_idx hold.
  - c_valid <= upd. It is high for exactly one cycle per updating edge and stays high across consecutive updating cycles.
- Latency: one cycle. A strobe sampled at edge k is reflected in counters, C, max_idx and c_valid after edge k.
- C can decrease: clearing the maximal channel while any strobe is active makes C the new maximum over the next values.
- Simultaneous INC on several channels in one cycle: all advance; the compare uses all new values.
- Ties: the lowest index always wins, including all-zero (max_idx=0).
- The comparator is a balanced reduction tree over nxt[]. Arithmetic is unsigned WIDTH-bit with no extension beyond WIDTH.
- NCH=2, WIDTH=8, SAT=0, CLR tied 0 is cycle-equivalent to the existing two-channel block for C, except for reset polarity/synchronicity.

Test Plan:
1. Reset: drive rst=0 for 2 cycles with INC=4'b1111 -> C=0, max_idx=0, c_valid=0, ovf=0. Release rst and apply 3 cycles of INC=4'b0100 -> C=3, max_idx=2, c_valid high for 3 cycles then 0 once INC=0.
2. Tie/priority: 5 cycles INC=4'b1010 -> C=5, max_idx=1. One more cycle with INC=4'b1000 -> C=6, max_idx=3. One idle cycle -> C holds at 6, c_valid=0.
3. Wrap (SAT=0): 255 INC on ch0 -> C=255, ovf=0. 256th INC -> cnt0=0, ovf[0]=1, C=0. Pulse CLR[0] -> ovf[0]=0, C=0.
4. Saturate (SAT=1): 300 INC on ch1 -> cnt1 stays 255, C=255, max_idx=1, ovf[1]=1 from the 256th strobe onward.
5. Clear priority: ch2=10, ch0=4, then one cycle of CLR[2]=1 with INC[2]=1 and INC[0]=1 -> cnt2=0, C=5, max_idx=0, c_valid=1.
6. Synchronous reset mid-run: counters at {7,3,9,1}, rst=0 for one cycle with INC active -> all outputs 0 after that edge. Then one INC=4'b0001 cycle -> C=1, max_idx=0.

Source files
------------

// File: rtl/inccomp_n.sv
// NCH saturating/wrapping event counters with a registered running maximum and winner index.
// Latency: one cycle from strobe to counters, C, max_idx, c_valid and ovf.
// No backpressure: every strobe is accepted on every rising ck edge.
module inccomp_n #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SAT   = 0,
  localparam int IW   = $clog2(NCH)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [NCH-1:0]   INC,
  input  logic [NCH-1:0]   CLR,
  output logic [WIDTH-1:0] C,
  output logic [IW-1:0]    max_idx,
  output logic             c_valid,
  output logic [NCH-1:0]   ovf
);

  // Leaf count of the comparator tree, padded up to a power of two.
  localparam int NP = 1 << IW;
  localparam logic [WIDTH-1:0] ALL1 = '1;

  logic [WIDTH-1:0] cnt [NCH];
  logic [WIDTH-1:0] nxt [NCH];
  logic [NCH-1:0]   ovf_nxt;
  logic [WIDTH-1:0] max_val;
  logic [IW-1:0]    max_pos;
  logic             upd;

  assign upd = |(INC | CLR);

  // Next count and next sticky overflow per channel; clear beats increment.
  always_comb begin
    ovf_nxt = ovf;
    for (int i = 0; i < NCH; i++) begin
      nxt[i] = cnt[i];
      if (CLR[i]) begin
        nxt[i]     = '0;
        ovf_nxt[i] = 1'b0;
      end else if (INC[i]) begin
        if (cnt[i] == ALL1) begin
          ovf_nxt[i] = 1'b1;
          nxt[i]     = (SAT != 0) ? ALL1 : '0;
        end else begin
          nxt[i] = cnt[i] + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Balanced pairwise max tree over the next values. On equal values the
  // left (lower-index) operand is kept, so the lowest index wins ties. Pad
  // leaves are zero with indices above every real channel, so they never win.
  always_comb begin
    logic [WIDTH-1:0] lv [NP];
    logic [IW-1:0]    li [NP];
    for (int j = 0; j < NP; j++) begin
      lv[j] = (j < NCH) ? nxt[j] : '0;
      li[j] = IW'(j);
    end
    for (int lvl = 0; lvl < IW; lvl++) begin
      for (int j = 0; j < (NP >> (lvl + 1)); j++) begin
        if (lv[2*j+1] > lv[2*j]) begin
          lv[j] = lv[2*j+1];
          li[j] = li[2*j+1];
        end else begin
          lv[j] = lv[2*j];
          li[j] = li[2*j];
        end
      end
    end
    max_val = lv[0];
    max_pos = li[0];
  end

  // State update: counters and flags every cycle, max/index only on strobe activity.
  always_ff @(posedge ck) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      ovf     <= '0;
      C       <= '0;
      max_idx <= '0;
      c_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) cnt[i] <= nxt[i];
      ovf     <= ovf_nxt;
      c_valid <= upd;
      if (upd) begin
        C       <= max_val;
        max_idx <= max_pos;
      end
    end
  end

endmodule

// File: tb/tb_inccomp_n.sv
module tb_inccomp_n;

  localparam int W = 8;
  localparam int N = 4;
  localparam int TOP = 255;

  logic       ck;
  logic       rst;
  logic [3:0] inc;
  logic [3:0] clr;

  logic [7:0] c0, c1;
  logic [1:0] idx0, idx1;
  logic       v0, v1;
  logic [3:0] ovf0, ovf1;

  int total = 0;
  int bad   = 0;

  // model state, index [m] = 0 wrap instance, 1 saturate instance
  int m_cnt [2][N];
  int m_ovf [2][N];
  int m_c   [2];
  int m_idx [2];
  int m_v   [2];

  inccomp_n #(.WIDTH(W), .NCH(N), .SAT(0)) dut0 (
    .ck(ck), .rst(rst), .INC(inc), .CLR(clr),
    .C(c0), .max_idx(idx0), .c_valid(v0), .ovf(ovf0));

  inccomp_n #(.WIDTH(W), .NCH(N), .SAT(1)) dut1 (
    .ck(ck), .rst(rst), .INC(inc), .CLR(clr),
    .C(c1), .max_idx(idx1), .c_valid(v1), .ovf(ovf1));

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer counters, max found by a linear scan.
  task automatic model_step(input logic [3:0] i_inc, input logic [3:0] i_clr, input logic r);
    for (int m = 0; m < 2; m++) begin
      if (!r) begin
        for (int i = 0; i < N; i++) begin
          m_cnt[m][i] = 0;
          m_ovf[m][i] = 0;
        end
        m_c[m] = 0; m_idx[m] = 0; m_v[m] = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (i_clr[i]) begin
            m_cnt[m][i] = 0;
            m_ovf[m][i] = 0;
          end else if (i_inc[i]) begin
            if (m_cnt[m][i] == TOP) begin
              m_ovf[m][i] = 1;
              m_cnt[m][i] = (m == 1) ? TOP : 0;
            end else begin
              m_cnt[m][i] = m_cnt[m][i] + 1;
            end
          end
        end
        m_v[m] = ((i_inc | i_clr) != 0) ? 1 : 0;
        if (m_v[m] != 0) begin
          m_c[m] = -1;
          for (int i = 0; i < N; i++)
            if (m_cnt[m][i] > m_c[m]) begin
              m_c[m]   = m_cnt[m][i];
              m_idx[m] = i;
            end
        end
      end
    end
  endtask

  function automatic logic [31:0] ovf_vec(input int m);
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = (m_ovf[m][i] != 0);
    return v;
  endfunction

  // One clock: drive, advance model at the edge, compare both instances 1 time unit later.
  task automatic cyc(input logic [3:0] i_inc, input logic [3:0] i_clr, input logic r);
    inc = i_inc; clr = i_clr; rst = r;
    @(posedge ck);
    model_step(i_inc, i_clr, r);
    #1;
    chk("w_C",   32'(c0),   32'(m_c[0]));
    chk("w_idx", 32'(idx0), 32'(m_idx[0]));
    chk("w_vld", 32'(v0),   32'(m_v[0]));
    chk("w_ovf", 32'(ovf0), ovf_vec(0));
    chk("s_C",   32'(c1),   32'(m_c[1]));
    chk("s_idx", 32'(idx1), 32'(m_idx[1]));
    chk("s_vld", 32'(v1),   32'(m_v[1]));
    chk("s_ovf", 32'(ovf1), ovf_vec(1));
  endtask

  initial begin
    inc = '0; clr = '0; rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) begin m_cnt[m][i] = 0; m_ovf[m][i] = 0; end
      m_c[m] = 0; m_idx[m] = 0; m_v[m] = 0;
    end

    // reset with increments active, then three increments on ch2
    cyc(4'b1111, 4'b0000, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b0);
    chk("rst_C", 32'(c0), 0);
    chk("rst_idx", 32'(idx0), 0);
    chk("rst_vld", 32'(v0), 0);
    chk("rst_ovf", 32'(ovf0), 0);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0100, 4'b0000, 1'b1);
      chk("p1_vld", 32'(v0), 1);
    end
    chk("p1_C", 32'(c0), 3);
    chk("p1_idx", 32'(idx0), 2);
    cyc(4'b0000, 4'b0000, 1'b1);
    chk("p1_vld_off", 32'(v0), 0);

    // tie between ch1 and ch3 resolves to ch1
    for (int k = 0; k < 5; k++) cyc(4'b1010, 4'b0000, 1'b1);
    chk("p2_C", 32'(c0), 5);
    chk("p2_idx", 32'(idx0), 1);
    cyc(4'b1000, 4'b0000, 1'b1);
    chk("p2_C6", 32'(c0), 6);
    chk("p2_idx3", 32'(idx0), 3);
    cyc(4'b0000, 4'b0000, 1'b1);
    chk("p2_hold", 32'(c0), 6);
    chk("p2_vld", 32'(v0), 0);

    // wrap vs saturate on ch0
    cyc(4'b0000, 4'b1111, 1'b1);
    for (int k = 0; k < 255; k++) cyc(4'b0001, 4'b0000, 1'b1);
    chk("p3_C255", 32'(c0), 255);
    chk("p3_ovf0", 32'(ovf0), 0);
    cyc(4'b0001, 4'b0000, 1'b1);
    chk("p3_wrapC", 32'(c0), 0);
    chk("p3_ovf1", 32'(ovf0), 1);
    chk("p3_satC", 32'(c1), 255);
    cyc(4'b0000, 4'b0001, 1'b1);
    chk("p3_clrovf", 32'(ovf0), 0);
    chk("p3_clrC", 32'(c0), 0);

    // saturate on ch1, 300 strobes
    for (int k = 1; k <= 300; k++) begin
      cyc(4'b0010, 4'b0000, 1'b1);
      if (k == 255) chk("p4_ovf_pre", 32'(ovf1[1]), 0);
      if (k == 256) chk("p4_ovf_set", 32'(ovf1[1]), 1);
    end
    chk("p4_C", 32'(c1), 255);
    chk("p4_idx", 32'(idx1), 1);
    chk("p4_ovf_end", 32'(ovf1[1]), 1);

    // clear beats increment on the maximal channel
    cyc(4'b0000, 4'b1111, 1'b1);
    for (int k = 0; k < 10; k++) cyc({1'b0, 1'b1, 1'b0, (k < 4)}, 4'b0000, 1'b1);
    chk("p5_pre", 32'(c0), 10);
    cyc(4'b0101, 4'b0100, 1'b1);
    chk("p5_C", 32'(c0), 5);
    chk("p5_idx", 32'(idx0), 0);
    chk("p5_vld", 32'(v0), 1);

    // synchronous reset mid-run
    cyc(4'b0000, 4'b1111, 1'b1);
    for (int k = 0; k < 9; k++)
      cyc({(k < 1), (k < 9), (k < 3), (k < 7)}, 4'b0000, 1'b1);
    chk("p6_pre", 32'(c0), 9);
    cyc(4'b1111, 4'b0000, 1'b0);
    chk("p6_C", 32'(c0), 0);
    chk("p6_vld", 32'(v0), 0);
    cyc(4'b0001, 4'b0000, 1'b1);
    chk("p6_C1", 32'(c0), 1);
    chk("p6_idx", 32'(idx0), 0);

    // random traffic, sparse clears and rare resets
    for (int k = 0; k < 600; k++) begin
      logic [3:0] ri, rc;
      logic rr;
      ri = 4'($urandom);
      rc = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      rr = ($urandom_range(0, 99) != 0);
      cyc(ri, rc, rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
